// File: rtl/rmii_rx_deframer_pkg.sv
// Shared constants, FSM encoding and helpers for the RMII receive deframer.
package rmii_rx_deframer_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [1:0] DIBIT_PRE = 2'b01;
    localparam logic [1:0] DIBIT_SFD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// Received byte stream: one-cycle strobes with frame delimiters and error flag.
interface rmii_rx_deframer_if;

    logic [7:0] data;
    logic       valid;
    logic       sop;
    logic       eop;
    logic       err;

    modport master (output data, valid, sop, eop, err);
    modport slave  (input  data, valid, sop, eop, err);

endinterface

// File: rtl/rmii_rx_deframer_crc32_d8.sv
// Byte-wise reflected CRC32 next-state; the caller owns the register.
module rmii_rx_deframer_crc32_d8
    import rmii_rx_deframer_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_c[0] ^ i_data[i])
                w_c = (w_c >> 1) ^ CRC_POLY;
            else
                w_c = w_c >> 1;
        end
    end

    assign o_crc = w_c;

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive front end: CRS_DV qualification, preamble/SFD strip,
// byte assembly with one-deep holding register, FCS/length/dribble checks.
module rmii_rx_deframer
    import rmii_rx_deframer_pkg::*;
#(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1522,
    parameter bit CHECK_FCS = 1'b1
)
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [1:0]                 i_rmii_rx,
    input  logic                       i_rmii_crs_dv,
    rmii_rx_deframer_if.master         o_rx,
    output logic [15:0]                o_frame_cnt,
    output logic [15:0]                o_err_cnt
);

    localparam logic [10:0] L_MIN  = 11'(MIN_BYTES);
    localparam logic [10:0] L_MAX  = 11'(MAX_BYTES);
    localparam logic [10:0] L_MAX1 = 11'(MAX_BYTES + 1);

    state_t      r_state;
    logic [1:0]  r_dibit;
    logic        r_dv_d;
    logic        r_armed;
    logic [1:0]  r_dcnt;
    logic [5:0]  r_shift;
    logic [10:0] r_len;
    logic [31:0] r_crc;
    logic [7:0]  r_held;
    logic        r_held_vld;
    logic        r_first;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_sop;
    logic        r_eop;
    logic        r_err;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    logic        w_commit;
    logic        w_end;
    logic [7:0]  w_byte;
    logic [31:0] w_crc_next;
    logic        w_err_eop;

    // A dibit is delayed one cycle so a lone CRS_DV low can still commit it.
    assign w_commit = r_dv_d | i_rmii_crs_dv;
    assign w_end    = ~r_dv_d & ~i_rmii_crs_dv;
    assign w_byte   = {r_dibit, r_shift};

    assign w_err_eop = (r_len < L_MIN) | (r_len > L_MAX) |
                       (r_dcnt != 2'd0) |
                       (CHECK_FCS && (r_crc != CRC_RESIDUE));

    rmii_rx_deframer_crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_dibit     <= 2'b00;
            r_dv_d      <= 1'b1;
            r_armed     <= 1'b0;
            r_dcnt      <= 2'd0;
            r_shift     <= 6'd0;
            r_len       <= 11'd0;
            r_crc       <= CRC_INIT;
            r_held      <= 8'd0;
            r_held_vld  <= 1'b0;
            r_first     <= 1'b0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_dibit <= i_rmii_rx;
            r_dv_d  <= i_rmii_crs_dv;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
            if (!r_armed)
                r_armed <= w_end;

            unique case (r_state)
                ST_IDLE: begin
                    if (r_armed && r_dv_d && r_dibit == DIBIT_PRE)
                        r_state <= ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                    end else if (w_commit) begin
                        if (r_dibit == DIBIT_SFD) begin
                            r_state    <= ST_DATA;
                            r_dcnt     <= 2'd0;
                            r_len      <= 11'd0;
                            r_crc      <= CRC_INIT;
                            r_held_vld <= 1'b0;
                            r_first    <= 1'b1;
                        end else if (r_dibit != DIBIT_PRE) begin
                            r_state   <= ST_DRAIN;
                            r_err_cnt <= sat_inc(r_err_cnt);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_end) begin
                        if (r_held_vld) begin
                            r_valid <= 1'b1;
                            r_data  <= r_held;
                            r_sop   <= r_first;
                            r_eop   <= 1'b1;
                            r_err   <= w_err_eop;
                            if (w_err_eop)
                                r_err_cnt <= sat_inc(r_err_cnt);
                            else
                                r_frame_cnt <= sat_inc(r_frame_cnt);
                            r_state <= ST_FLUSH;
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_commit) begin
                        r_dcnt  <= r_dcnt + 2'd1;
                        r_shift <= {r_dibit, r_shift[5:2]};
                        if (r_dcnt == 2'd3) begin
                            if (r_len != L_MAX1)
                                r_len <= r_len + 11'd1;
                            // Bytes past the maximum are counted but dropped.
                            if (r_len < L_MAX) begin
                                r_crc      <= w_crc_next;
                                r_held     <= w_byte;
                                r_held_vld <= 1'b1;
                                if (r_held_vld) begin
                                    r_valid <= 1'b1;
                                    r_data  <= r_held;
                                    r_sop   <= r_first;
                                    r_first <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (w_end)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx.data   = r_data;
    assign o_rx.valid  = r_valid;
    assign o_rx.sop    = r_sop;
    assign o_rx.eop    = r_eop;
    assign o_rx.err    = r_err;
    assign o_frame_cnt = r_frame_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule
